// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory response model: command/type codes,
// FSM state encoding, widths and access-size helpers.
package mem_resp_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned ADDR_W = 40;
    localparam int unsigned CMD_W  = 5;
    localparam int unsigned TYP_W  = 3;
    localparam int unsigned CNT_W  = 4;

    // Command codes; anything else is a no-op
    localparam logic [CMD_W-1:0] M_XRD = 5'd0;
    localparam logic [CMD_W-1:0] M_XWR = 5'd1;

    // Access size/sign codes; code 7 behaves like MT_D
    localparam logic [TYP_W-1:0] MT_B  = 3'd0;
    localparam logic [TYP_W-1:0] MT_H  = 3'd1;
    localparam logic [TYP_W-1:0] MT_W  = 3'd2;
    localparam logic [TYP_W-1:0] MT_D  = 3'd3;
    localparam logic [TYP_W-1:0] MT_BU = 3'd4;
    localparam logic [TYP_W-1:0] MT_HU = 3'd5;
    localparam logic [TYP_W-1:0] MT_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // log2 of access size in bytes
    function automatic logic [1:0] typ_size(input logic [TYP_W-1:0] typ);
        case (typ)
            MT_B, MT_BU: typ_size = 2'd0;
            MT_H, MT_HU: typ_size = 2'd1;
            MT_W, MT_WU: typ_size = 2'd2;
            default:     typ_size = 2'd3;
        endcase
    endfunction

    // Signed codes are 0..3; doublewords need no extension anyway
    function automatic logic typ_signed(input logic [TYP_W-1:0] typ);
        typ_signed = ~typ[2];
    endfunction

endpackage

// File: rtl/mem_resp_lane.sv
// Subword lane logic: load extract/extend and store byte-lane merge.
// Only used when MEM_RESP_MODEL_SUBWORD_EN is defined.
module mem_resp_lane
    import mem_resp_pkg::*;
(
    input  logic [2:0]  typ_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] ld_data_c,
    output logic [63:0] st_word_c
);

    logic [1:0]  size;
    logic        sgn;
    logic [2:0]  lane_off;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] mask;
    logic        msb;
    logic [63:0] lane_mask;

    // Align the byte offset to the access size, then extract/extend and merge
    always_comb begin
        size      = typ_size(typ_i);
        sgn       = typ_signed(typ_i);
        lane_off  = 3'd0;
        mask      = '1;
        msb       = 1'b0;
        case (size)
            2'd0:    lane_off = off_i;
            2'd1:    lane_off = {off_i[2:1], 1'b0};
            2'd2:    lane_off = {off_i[2], 2'b00};
            default: lane_off = 3'd0;
        endcase
        shamt   = 6'({lane_off, 3'b000});
        shifted = word_i >> shamt;
        case (size)
            2'd0: begin
                mask = 64'h0000_0000_0000_00FF;
                msb  = shifted[7];
            end
            2'd1: begin
                mask = 64'h0000_0000_0000_FFFF;
                msb  = shifted[15];
            end
            2'd2: begin
                mask = 64'h0000_0000_FFFF_FFFF;
                msb  = shifted[31];
            end
            default: begin
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        ld_data_c = shifted & mask;
        if (sgn && msb) begin
            ld_data_c = ld_data_c | ~mask;
        end
        lane_mask = mask << shamt;
        st_word_c = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);
    end

endmodule

// File: rtl/mem_resp_model.sv
// Single-outstanding memory responder with fixed accept-to-response latency.
// Optional feature macro: MEM_RESP_MODEL_SUBWORD_EN (subword loads/stores);
// without it every access is a full 64-bit doubleword.
module mem_resp_model
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_vld,
    output logic        mem_req_rdy,
    input  logic [39:0] mem_req_addr,
    input  logic [4:0]  mem_req_cmd,
    input  logic [2:0]  mem_req_typ,
    input  logic [63:0] mem_req_data,
    output logic        mem_resp_vld,
    output logic [63:0] mem_resp_data,
    output logic [63:0] mem_resp_store_data
);

    localparam int unsigned     DEPTH    = 1 << ADDR_BITS;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    logic [63:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic                 accept;
    logic                 is_ld;
    logic                 is_st;
    logic [63:0]          rd_word;
    logic [63:0]          ld_val;
    logic [63:0]          st_word;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rdy_q, rdy_d;
    logic                 vld_q, vld_d;
    logic [63:0]          resp_data_q, resp_data_d;
    logic [63:0]          resp_store_q, resp_store_d;
    logic                 unused_req_bits;

    assign idx     = mem_req_addr[ADDR_BITS+2:3];
    assign accept  = mem_req_vld && rdy_q;
    assign is_ld   = (mem_req_cmd == M_XRD);
    assign is_st   = (mem_req_cmd == M_XWR);
    assign rd_word = mem_q[idx];

    // High address bits alias by design; offset/typ are dropped in full-word builds
    assign unused_req_bits = ^{mem_req_addr, mem_req_typ};

`ifdef MEM_RESP_MODEL_SUBWORD_EN
    mem_resp_lane u_lane (
        .typ_i     (mem_req_typ),
        .off_i     (mem_req_addr[2:0]),
        .word_i    (rd_word),
        .wdata_i   (mem_req_data),
        .ld_data_c (ld_val),
        .st_word_c (st_word)
    );
`else
    assign ld_val  = rd_word;
    assign st_word = mem_req_data;
`endif

    // Memory array: written in the accept cycle, never reset
    always_ff @(posedge clk) begin
        if (accept && is_st) begin
            mem_q[idx] <= st_word;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rdy_q        <= 1'b1;
            vld_q        <= 1'b0;
            resp_data_q  <= '0;
            resp_store_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rdy_q        <= rdy_d;
            vld_q        <= vld_d;
            resp_data_q  <= resp_data_d;
            resp_store_q <= resp_store_d;
        end
    end

    // Next-state, latency counter and response payload capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_store_d = resp_store_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                    resp_data_d  = is_ld ? ld_val : 64'd0;
                    resp_store_d = is_st ? mem_req_data : 64'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        rdy_d = (state_d == ST_IDLE);
        vld_d = (state_d == ST_RESP);
    end

    assign mem_req_rdy         = rdy_q;
    assign mem_resp_vld        = vld_q;
    assign mem_resp_data       = resp_data_q;
    assign mem_resp_store_data = resp_store_q;

endmodule

// File: tb/tb_mem_resp_model.sv
// Directed bench for mem_resp_model: three instances with LATENCY 2, 4 and 1.
module tb_mem_resp_model;
    import mem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld  [3];
    logic        rdy  [3];
    logic        rvld [3];
    logic [39:0] addr [3];
    logic [4:0]  cmd  [3];
    logic [2:0]  typ  [3];
    logic [63:0] wd   [3];
    logic [63:0] rd   [3];
    logic [63:0] sd   [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_resp_model #(
            .ADDR_BITS (10),
            .LATENCY   (g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .mem_req_vld         (vld[g]),
            .mem_req_rdy         (rdy[g]),
            .mem_req_addr        (addr[g]),
            .mem_req_cmd         (cmd[g]),
            .mem_req_typ         (typ[g]),
            .mem_req_data        (wd[g]),
            .mem_resp_vld        (rvld[g]),
            .mem_resp_data       (rd[g]),
            .mem_resp_store_data (sd[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request and return at the negedge of the cycle after its accept
    task automatic issue(input int d, input logic [4:0] c, input logic [2:0] t,
                         input logic [39:0] a, input logic [63:0] w);
        int n;
        @(negedge clk);
        vld[d] = 1'b1; cmd[d] = c; typ[d] = t; addr[d] = a; wd[d] = w;
        n = 0;
        while (!rdy[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept rdy", 64'(rdy[d]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        vld[d] = 1'b0;
    endtask

    // Full transaction: latency, payload, one-cycle strobe, rdy and data hold
    task automatic txn(input string tag, input int d, input logic [4:0] c, input logic [2:0] t,
                       input logic [39:0] a, input logic [63:0] w,
                       input logic [63:0] exp_rd, input logic [63:0] exp_sd);
        int k;
        issue(d, c, t, a, w);
        k = 1;
        while (!rvld[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(lat_of(d)));
        check({tag, " resp_data"}, rd[d], exp_rd);
        check({tag, " store_data"}, sd[d], exp_sd);
        check({tag, " rdy in resp"}, 64'(rdy[d]), 64'd0);
        @(negedge clk);
        check({tag, " vld one cycle"}, 64'(rvld[d]), 64'd0);
        check({tag, " rdy after"}, 64'(rdy[d]), 64'd1);
        check({tag, " data hold"}, rd[d], exp_rd);
    endtask

    initial begin
        int j;
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0; addr[i] = '0; cmd[i] = '0; typ[i] = '0; wd[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset rdy", 64'(rdy[i]), 64'd1);
            check("reset vld", 64'(rvld[i]), 64'd0);
            check("reset rd", rd[i], 64'd0);
            check("reset sd", sd[i], 64'd0);
        end
        rst = 1'b0;

        // Store then load, latency 2
        txn("st40", 0, M_XWR, MT_D, 40'h40, 64'h1122334455667788, 64'd0, 64'h1122334455667788);
        txn("ld40", 0, M_XRD, MT_D, 40'h40, 64'd0, 64'h1122334455667788, 64'd0);

        // Aliasing with vld held high across two requests
        @(negedge clk);
        vld[0] = 1'b1; cmd[0] = M_XWR; typ[0] = MT_D; addr[0] = 40'h2008; wd[0] = 64'hAB;
        check("b2b first rdy", 64'(rdy[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd[0] = M_XRD; addr[0] = 40'h0008; wd[0] = 64'd0;
        j = 1;
        while (!rdy[0] && j < 20) begin
            @(negedge clk);
            j++;
        end
        check("b2b accept gap", 64'(j), 64'd3);
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        j = 1;
        while (!rvld[0] && j < 20) begin
            @(negedge clk);
            j++;
        end
        check("alias latency", 64'(j), 64'd2);
        check("alias data", rd[0], 64'hAB);

        // No-op commands leave memory untouched and return zeros
        txn("st10", 0, M_XWR, MT_D, 40'h10, 64'h0123456789ABCDEF, 64'd0, 64'h0123456789ABCDEF);
        txn("nop3", 0, 5'd3, MT_D, 40'h10, 64'hDEADBEEFDEADBEEF, 64'd0, 64'd0);
        txn("nop31", 0, 5'd31, MT_D, 40'h10, 64'h5555AAAA5555AAAA, 64'd0, 64'd0);
        txn("ld10", 0, M_XRD, MT_D, 40'h10, 64'd0, 64'h0123456789ABCDEF, 64'd0);

        // Latency 1
        txn("l1 st", 2, M_XWR, MT_D, 40'h100, 64'hFEDCBA9876543210, 64'd0, 64'hFEDCBA9876543210);
        txn("l1 ld", 2, M_XRD, MT_D, 40'h100, 64'd0, 64'hFEDCBA9876543210, 64'd0);

        // Reset during WAIT on the latency-4 instance
        issue(1, M_XWR, MT_D, 40'h18, 64'hCAFEF00D12345678);
        rst = 1'b1;
        #1;
        check("midrst rdy", 64'(rdy[1]), 64'd1);
        check("midrst vld", 64'(rvld[1]), 64'd0);
        check("midrst sd", sd[1], 64'd0);
        check("midrst rd", rd[1], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rvld[1]) seen++;
        end
        check("midrst no resp", 64'(seen), 64'd0);
        txn("midrst ld", 1, M_XRD, MT_D, 40'h18, 64'd0, 64'hCAFEF00D12345678, 64'd0);

`ifdef MEM_RESP_MODEL_SUBWORD_EN
        txn("sw init", 0, M_XWR, MT_D, 40'h0, 64'hFFFFFFFF80FF7F01, 64'd0, 64'hFFFFFFFF80FF7F01);
        txn("sw lb1", 0, M_XRD, MT_B, 40'h1, 64'd0, 64'h7F, 64'd0);
        txn("sw lb2", 0, M_XRD, MT_B, 40'h2, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd0);
        txn("sw lbu2", 0, M_XRD, MT_BU, 40'h2, 64'd0, 64'hFF, 64'd0);
        txn("sw lw3", 0, M_XRD, MT_W, 40'h3, 64'd0, 64'hFFFFFFFF80FF7F01, 64'd0);
        txn("sw sh4", 0, M_XWR, MT_H, 40'h4, 64'hBEEF, 64'd0, 64'hBEEF);
        txn("sw ld", 0, M_XRD, MT_D, 40'h0, 64'd0, 64'hFFFFBEEF80FF7F01, 64'd0);
        txn("sw lhu5", 0, M_XRD, MT_HU, 40'h5, 64'd0, 64'hBEEF, 64'd0);
        txn("sw lh4", 0, M_XRD, MT_H, 40'h4, 64'd0, 64'hFFFFFFFFFFFFBEEF, 64'd0);
        txn("sw lwu4", 0, M_XRD, MT_WU, 40'h4, 64'd0, 64'hFFFFBEEF, 64'd0);
        txn("sw typ7", 0, M_XRD, 3'd7, 40'h0, 64'd0, 64'hFFFFBEEF80FF7F01, 64'd0);
`else
        txn("fw init", 0, M_XWR, MT_D, 40'h0, 64'hFFFFFFFF80FF7F01, 64'd0, 64'hFFFFFFFF80FF7F01);
        txn("fw lb2", 0, M_XRD, MT_B, 40'h2, 64'd0, 64'hFFFFFFFF80FF7F01, 64'd0);
        txn("fw sh4", 0, M_XWR, MT_H, 40'h4, 64'hBEEF, 64'd0, 64'hBEEF);
        txn("fw lb1", 0, M_XRD, MT_BU, 40'h1, 64'd0, 64'hBEEF, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_resp_model.md
MEM_RESP_MODEL -- requirements
Module: mem_resp_model

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 10, word-index width (2^ADDR_BITS 64-bit words); LATENCY, default 2, legal range 1..15, cycles from accept to response.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 mem_req_vld  in  1  request valid.
REQ-005 mem_req_rdy  out  1  responder can accept a request.
REQ-006 mem_req_addr  in  40  byte address.
REQ-007 mem_req_cmd  in  5  command: 0 = load, 1 = store, others = no-op.
REQ-008 mem_req_typ  in  3  access size/sign code.
REQ-009 mem_req_data  in  64  store data, LSB-aligned.
REQ-010 mem_resp_vld  out  1  one-cycle response strobe; there is no response backpressure.
REQ-011 mem_resp_data  out  64  load result.
REQ-012 mem_resp_store_data  out  64  store data echo.

Function
REQ-013 A request SHALL be accepted in a cycle where mem_req_vld && mem_req_rdy are both high.
REQ-014 The FSM SHALL have three states:
- IDLE: rdy=1. On accept, go to WAIT with counter=LATENCY-1, or go to RESP if LATENCY=1.
- WAIT: rdy=0. Decrement the counter; at 0, go to RESP.
- RESP: rdy=0, resp_vld=1 for exactly one cycle, then go to IDLE.
REQ-015 If accepted in cycle N, mem_resp_vld SHALL be high only in cycle N+LATENCY; one request outstanding at most; the next accept is possible in cycle N+LATENCY+1.
REQ-016 Word index SHALL be addr[ADDR_BITS+2:3]; higher address bits are ignored, so addresses alias with wrap-around.
REQ-017 Load: the addressed word SHALL be read and extracted in the accept cycle and held in a register. mem_resp_data = extracted value; mem_resp_store_data = 0.
REQ-018 Store: memory SHALL be written in the accept cycle. mem_resp_store_data = the 64-bit mem_req_data as accepted; mem_resp_data = 0.
REQ-019 No-op cmd: no memory access; a response SHALL still be produced at the same latency, with both data outputs 0.
REQ-020 The response data outputs SHALL hold their values until the next response is loaded.
REQ-021 A load issued right after a store to the same word SHALL return the stored data.

Reset
REQ-022 While rst is high, the block SHALL be in state IDLE, with counter=0, mem_req_rdy=1, mem_resp_vld=0, mem_resp_data=0 and mem_resp_store_data=0.
REQ-023 Memory array contents SHALL NOT be reset.
REQ-024 On reset mid-operation, the pending response SHALL be dropped and never emitted; a store already accepted remains written.

Configuration
REQ-025 With macro MEM_RESP_MODEL_SUBWORD_EN defined, typ SHALL select access width and sign handling:
- typ 0/1/2/3 = byte/half/word/double, sign-extended.
- typ 4/5/6 = unsigned byte/half/word.
- typ 7 is treated as 3.
REQ-026 With MEM_RESP_MODEL_SUBWORD_EN defined, the subword lane SHALL be at byte offset addr[2:0] aligned down to the access size. A load extracts and extends the lane. A store merges the low bytes of mem_req_data into that lane only.
REQ-027 Without the macro, typ and addr[2:0] SHALL be ignored and every access is a full 64-bit doubleword.

Structure
REQ-028 Package mem_resp_pkg SHALL hold:
- Command codes: M_XRD=0, M_XWR=1.
- Typ codes: MT_B, MT_H, MT_W, MT_D, MT_BU, MT_HU, MT_WU.
- FSM state encodings.
REQ-029 Sub-module mem_resp_lane (combinational) SHALL do load extract/extend and store byte-mask merge; it is instantiated only under MEM_RESP_MODEL_SUBWORD_EN.

Verification
REQ-030 Store then load, LATENCY=2: store addr 0x40, data 0x1122334455667788, accepted cycle N -> resp_vld in N+2, store_data=0x1122334455667788. A load from 0x40 then returns 0x1122334455667788.
REQ-031 Aliasing, ADDR_BITS=10: store 0xAB at 0x2008, then load 0x0008 -> returns 0xAB. Back-to-back vld held high -> second accept occurs exactly at N+LATENCY+1.
REQ-032 Subword (macro on): word 0x0 holds 0xFFFFFFFF80FF7F01.
- Load typ 0 at addr 0x1 -> 0x7F.
- Load typ 0 at addr 0x2 -> 0xFFFFFFFFFFFFFFFF.
- Load typ 4 at addr 0x2 -> 0xFF.
- Store typ 1 of 0xBEEF at addr 0x4 -> word becomes 0xFFFFBEEF80FF7F01.
REQ-033 No-op: cmd 5'd3 at 0x10 -> response at latency with both data outputs 0; memory unchanged.
REQ-034 Reset mid-WAIT, LATENCY=4: assert rst at N+1 -> no resp_vld ever for that request; rdy=1 immediately; the store before reset is readable afterwards.
REQ-035 LATENCY=1: accept at N -> resp_vld only at N+1; rdy low at N+1, high at N+2.
